eth_tx_arbiter: RTL and testbench



---
 rtl/eth_arb_pkg.sv | 21 ++
 rtl/eth_tx_arbiter_rr_pick.sv | 31 +++
 rtl/eth_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_arb_pkg.sv
// Shared types and widths for the Ethernet TX arbiter.
// Used by rr_pick and eth_tx_arbiter.
package eth_arb_pkg;

  localparam int ETH_DATA_W  = 256;
  localparam int ETH_EMPTY_W = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } t_arb_state;

  typedef struct packed {
    logic [ETH_DATA_W-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [ETH_EMPTY_W-1:0] empty;
    logic                   error;
  } t_eth_beat;

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// Circular priority picker: first request after ptr_i wins.
// Pure combinational, one-hot grant plus valid.
import eth_arb_pkg::*;

module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          vld_o
);

  always_comb begin : pick
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    gnt_o = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-locked round-robin merge of NIC TX streams onto the MAC.
// Optional per-port packet counters: define ETH_TX_ARB_STATS_EN.
import eth_arb_pkg::*;

module eth_tx_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = ETH_DATA_W,
  parameter int EMPTY_W   = ETH_EMPTY_W
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_PORTS-1:0]               in_valid,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]   in_data,
  input  logic [NUM_PORTS-1:0]               in_sop,
  input  logic [NUM_PORTS-1:0]               in_eop,
  input  logic [NUM_PORTS-1:0][EMPTY_W-1:0]  in_empty,
  input  logic [NUM_PORTS-1:0]               in_error,
  output logic [NUM_PORTS-1:0]               in_ready,
  output logic                               out_valid,
  output logic [DATA_W-1:0]                  out_data,
  output logic                               out_sop,
  output logic                               out_eop,
  output logic [EMPTY_W-1:0]                 out_empty,
  output logic                               out_error,
  input  logic                               out_ready,
  output logic [NUM_PORTS-1:0]               grant_out,
`ifdef ETH_TX_ARB_STATS_EN
  output logic [NUM_PORTS-1:0][31:0]         pkt_count_out,
`endif
  output logic [NUM_PORTS-1:0]               stray_out
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  t_arb_state            state_q;
  logic [PW-1:0]         rr_ptr_q;
  logic [PW-1:0]         gidx_q;
  logic [NUM_PORTS-1:0]  grant_q;
  logic [NUM_PORTS-1:0]  stray_q;
  logic                  out_valid_q;
  logic [DATA_W-1:0]     out_data_q;
  logic                  out_sop_q;
  logic                  out_eop_q;
  logic [EMPTY_W-1:0]    out_empty_q;
  logic                  out_error_q;

  logic [NUM_PORTS-1:0]  elig;
  logic [NUM_PORTS-1:0]  win_oh;
  logic                  win_vld;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         sel;
  logic [NUM_PORTS-1:0]  ready_d;
  logic [NUM_PORTS-1:0]  stray_d;
  logic                  slot_free;
  logic                  acc;

  assign elig      = in_valid & in_sop;
  assign slot_free = !out_valid_q || out_ready;

  rr_pick #(
    .N  (NUM_PORTS),
    .PW (PW)
  ) u_pick (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_oh),
    .vld_o (win_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_oh[i]) win_idx = PW'(i);
    end
  end

  // Strays are never the winner: the winner always carries SOP.
  always_comb begin
    ready_d = '0;
    stray_d = '0;
    sel     = (state_q == IDLE) ? win_idx : gidx_q;
    if (reset_n) begin
      unique case (state_q)
        IDLE: begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (in_valid[i] && !in_sop[i]) begin
              ready_d[i] = 1'b1;
              stray_d[i] = 1'b1;
            end
          end
          if (win_vld) ready_d[win_idx] = slot_free;
        end
        LOCKED: ready_d[gidx_q] = slot_free;
        default: ;
      endcase
    end
    acc = in_valid[sel] && ready_d[sel] &&
          ((state_q == LOCKED) || win_vld);
  end

  assign in_ready = ready_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= PW'(NUM_PORTS - 1);
      gidx_q      <= '0;
      grant_q     <= '0;
      stray_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= '0;
      out_error_q <= 1'b0;
    end else begin
      stray_q <= stray_d;
      if (acc) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data[sel];
        out_sop_q   <= in_sop[sel];
        out_eop_q   <= in_eop[sel];
        out_empty_q <= in_empty[sel];
        out_error_q <= in_error[sel];
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            if (in_eop[sel]) begin
              rr_ptr_q <= sel;
            end else begin
              state_q <= LOCKED;
              gidx_q  <= sel;
              grant_q <= win_oh;
            end
          end
        end
        LOCKED: begin
          if (acc && in_eop[sel]) begin
            state_q  <= IDLE;
            rr_ptr_q <= gidx_q;
            grant_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ETH_TX_ARB_STATS_EN
  logic [NUM_PORTS-1:0][31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (acc && in_eop[sel]) begin
      cnt_q[sel] <= cnt_q[sel] + 32'd1;
    end
  end

  assign pkt_count_out = cnt_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_empty = out_empty_q;
  assign out_error = out_error_q;
  assign grant_out = grant_q;
  assign stray_out = stray_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: per-port sources,
// expected beats queued at stimulus time, popped at the output.
module tb_eth_tx_arbiter;

  localparam int NP = 3;

  typedef struct {
    logic [255:0] data;
    logic         sop;
    logic         eop;
    logic [4:0]   empty;
    logic         err;
    logic [2:0]   gnt;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NP-1:0]        in_valid = '0;
  logic [NP-1:0][255:0] in_data = '0;
  logic [NP-1:0]        in_sop = '0;
  logic [NP-1:0]        in_eop = '0;
  logic [NP-1:0][4:0]   in_empty = '0;
  logic [NP-1:0]        in_error = '0;
  logic [NP-1:0]        in_ready;
  logic                 out_valid;
  logic [255:0]         out_data;
  logic                 out_sop;
  logic                 out_eop;
  logic [4:0]           out_empty;
  logic                 out_error;
  logic                 out_ready;
  logic [NP-1:0]        grant_out;
  logic [NP-1:0]        stray_out;
`ifdef ETH_TX_ARB_STATS_EN
  logic [NP-1:0][31:0]  pkt_count_out;
`endif

  eth_tx_arbiter #(.NUM_PORTS(NP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_empty  (in_empty),
    .in_error  (in_error),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_empty (out_empty),
    .out_error (out_error),
    .out_ready (out_ready),
    .grant_out (grant_out),
`ifdef ETH_TX_ARB_STATS_EN
    .pkt_count_out (pkt_count_out),
`endif
    .stray_out (stray_out)
  );

  always #5 clk = ~clk;

  int    errs   = 0;
  int    checks = 0;
  beat_t src_q[NP][$];
  beat_t exp_q[$];
  int    exp_cnt[NP];
  logic [NP-1:0] acc_s = '0;
  beat_t drv_b;
  beat_t mon_b;

  task automatic check(input string tag, input logic [271:0] got,
                       input logic [271:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [271:0] pk(beat_t b);
    return {5'd0, b.data, b.sop, b.eop, b.empty, b.err, b.gnt};
  endfunction

  function automatic logic [271:0] pk_out();
    return {5'd0, out_data, out_sop, out_eop, out_empty, out_error,
            grant_out};
  endfunction

  task automatic send_pkt(input int p, input int n,
                          input logic [4:0] emp, input logic err_last);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data  = {8{32'($urandom)}};
      b.data[7:0] = 8'(p);
      b.sop   = (k == 0);
      b.eop   = (k == n - 1);
      b.empty = b.eop ? emp : 5'd0;
      b.err   = b.eop ? err_last : 1'b0;
      b.gnt   = b.eop ? 3'b000 : 3'(1 << p);
      src_q[p].push_back(b);
      exp_q.push_back(b);
    end
    exp_cnt[p]++;
  endtask

  task automatic send_stray(input int p);
    beat_t b;
    b.data  = {8{32'($urandom)}};
    b.sop   = 1'b0;
    b.eop   = 1'b0;
    b.empty = 5'd0;
    b.err   = 1'b0;
    b.gnt   = 3'b000;
    src_q[p].push_back(b);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && src_q[0].size() == 0 &&
          src_q[1].size() == 0 && src_q[2].size() == 0) break;
    end
    if (i == 300) check("timeout_idle", 272'(exp_q.size()), 272'(0));
  endtask

  task automatic wait_grant(input logic [2:0] g);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (grant_out == g) break;
    end
    if (i == 100) check("timeout_grant", 272'(grant_out), 272'(g));
  endtask

  task automatic count_run(input int n);
    int c;
    c = 0;
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    while (out_valid && c < 20) begin
      c++;
      @(negedge clk);
    end
    check("run_len", 272'(c), 272'(n));
  endtask

  task automatic check_cnt();
`ifdef ETH_TX_ARB_STATS_EN
    for (int p = 0; p < NP; p++)
      check($sformatf("pkt_count%0d", p), 272'(pkt_count_out[p]),
            272'(exp_cnt[p]));
`endif
  endtask

  always @(negedge clk) acc_s = in_valid & in_ready;

  always @(posedge clk) begin
    #1;
    for (int p = 0; p < NP; p++) begin
      if (acc_s[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
      if (src_q[p].size() > 0) begin
        drv_b       = src_q[p][0];
        in_valid[p] = 1'b1;
        in_data[p]  = drv_b.data;
        in_sop[p]   = drv_b.sop;
        in_eop[p]   = drv_b.eop;
        in_empty[p] = drv_b.empty;
        in_error[p] = drv_b.err;
      end else begin
        in_valid[p] = 1'b0;
        in_data[p]  = '0;
        in_sop[p]   = 1'b0;
        in_eop[p]   = 1'b0;
        in_empty[p] = '0;
        in_error[p] = 1'b0;
      end
    end
    acc_s = '0;
  end

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("no_extra_beat", 272'(out_valid), 272'(0));
      end else begin
        mon_b = exp_q.pop_front();
        check("beat", pk_out(), pk(mon_b));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    out_ready = 1'b1;
    for (int p = 0; p < NP; p++) exp_cnt[p] = 0;

    send_pkt(0, 3, 5'd7, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_in_ready", 272'(in_ready), 272'(0));
    check("rst_out_valid", 272'(out_valid), 272'(0));
    check("rst_out_data", 272'(out_data), 272'(0));
    check("rst_grant", 272'(grant_out), 272'(0));
    check("rst_stray", 272'(stray_out), 272'(0));
`ifdef ETH_TX_ARB_STATS_EN
    check("rst_cnt", 272'(pkt_count_out), 272'(0));
`endif
    @(posedge clk); #1 reset_n = 1'b1;
    wait_idle();

    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
    @(negedge clk);
    send_pkt(0, 2, 5'd3, 1'b0);
    send_pkt(1, 2, 5'd0, 1'b1);
    send_pkt(2, 2, 5'd31, 1'b0);
    count_run(6);
    wait_idle();
    check_cnt();

    @(negedge clk);
    send_pkt(1, 4, 5'd2, 1'b0);
    wait_grant(3'b010);
    send_pkt(2, 2, 5'd4, 1'b0);
    send_pkt(0, 2, 5'd9, 1'b0);
    @(negedge clk);
    check("lock_rdy0", 272'(in_ready[0]), 272'(0));
    check("lock_rdy2", 272'(in_ready[2]), 272'(0));
    wait_idle();

    @(negedge clk);
    send_pkt(2, 6, 5'd1, 1'b0);
    wait_grant(3'b100);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (exp_q.size() > 0) check("bp_hold", pk_out(), pk(exp_q[0]));
      check("bp_valid", 272'(out_valid), 272'(1));
      check("bp_rdy", 272'(in_ready), 272'(0));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();

    @(negedge clk);
    send_pkt(1, 1, 5'd0, 1'b0);
    wait_idle();
    @(negedge clk);
    send_pkt(2, 1, 5'd6, 1'b0);
    send_pkt(0, 2, 5'd0, 1'b0);
    count_run(3);
    wait_idle();

    @(negedge clk);
    send_stray(1);
    for (int i = 0; i < 20 && !in_valid[1]; i++) @(negedge clk);
    @(negedge clk);
    check("stray_pulse", 272'(stray_out), 272'(3'b010));
    @(negedge clk);
    check("stray_clear", 272'(stray_out), 272'(0));
    wait_idle();
    check_cnt();

    @(negedge clk);
    send_pkt(1, 6, 5'd0, 1'b0);
    wait_grant(3'b010);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", 272'(out_valid), 272'(0));
    check("mid_rst_grant", 272'(grant_out), 272'(0));
    check("mid_rst_ready", 272'(in_ready), 272'(0));
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_cnt[p] = 0;
    end
    check_cnt();
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    send_pkt(0, 2, 5'd11, 1'b0);
    send_pkt(1, 2, 5'd12, 1'b0);
    send_pkt(2, 2, 5'd13, 1'b0);
    count_run(6);
    wait_idle();
    check_cnt();

    repeat (3) @(negedge clk);
    check("end_out_valid", 272'(out_valid), 272'(0));
    check("end_queue", 272'(exp_q.size()), 272'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
